// File: rtl/p_div_if.sv
// Request/result bundle for the p_div serial divider.
// Handshake: in_valid is sampled only while busy=0; a result is a one-cycle out_valid pulse.
interface p_div_if;
  logic        in_valid;
  logic [95:0] in_dividend;
  logic [47:0] in_divisor;
  logic        busy;
  logic        out_valid;
  logic [95:0] out_quot;
  logic [47:0] out_rem;
  logic        out_dz;
  logic [1:0]  dbg_state;

  modport master (
    output in_valid, in_dividend, in_divisor,
    input  busy, out_valid, out_quot, out_rem, out_dz, dbg_state
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    output busy, out_valid, out_quot, out_rem, out_dz, dbg_state
  );
endinterface

// File: rtl/p_div.sv
// 96/48-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Divide-by-zero short-circuits straight to DONE with a flagged result.
module p_div (
  input  logic      clk,
  input  logic      rst_n,
  p_div_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;

  // quot_q starts as the dividend: its MSB feeds the partial remainder while
  // each new quotient bit enters at the LSB, so after 96 steps it holds the quotient.
  logic [95:0] quot_q, quot_nxt;
  logic [47:0] prem_q, prem_nxt;
  logic [47:0] dvs_q, dvs_nxt;
  logic [6:0]  cnt_q, cnt_nxt;

  logic [95:0] res_quot_q, res_quot_nxt;
  logic [47:0] res_rem_q, res_rem_nxt;
  logic        res_dz_q, res_dz_nxt;

  logic [48:0] trial;
  logic [47:0] sub;
  logic        q_bit;
  logic [47:0] rem_step;
  logic [95:0] quot_step;
  logic        last_step;

  // The partial remainder is always < divisor, so the 49-bit trial value's
  // difference fits in 48 bits whenever the subtraction is taken.
  always_comb begin
    trial     = {prem_q, quot_q[95]};
    q_bit     = (trial >= {1'b0, dvs_q});
    sub       = trial[47:0] - dvs_q;
    rem_step  = q_bit ? sub : trial[47:0];
    quot_step = {quot_q[94:0], q_bit};
    last_step = (cnt_q == 7'd95);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    quot_nxt     = quot_q;
    prem_nxt     = prem_q;
    dvs_nxt      = dvs_q;
    cnt_nxt      = cnt_q;
    res_quot_nxt = res_quot_q;
    res_rem_nxt  = res_rem_q;
    res_dz_nxt   = res_dz_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          quot_nxt = bus.in_dividend;
          prem_nxt = '0;
          dvs_nxt  = bus.in_divisor;
          cnt_nxt  = '0;
          if (bus.in_divisor == '0) begin
            state_nxt    = DONE;
            res_quot_nxt = '1;
            res_rem_nxt  = bus.in_dividend[47:0];
            res_dz_nxt   = 1'b1;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        quot_nxt = quot_step;
        prem_nxt = rem_step;
        cnt_nxt  = cnt_q + 7'd1;
        if (last_step) begin
          state_nxt    = DONE;
          res_quot_nxt = quot_step;
          res_rem_nxt  = rem_step;
          res_dz_nxt   = 1'b0;
        end
      end
      DONE: begin
        // Result registers return to zero so outputs read 0 outside out_valid.
        state_nxt    = IDLE;
        res_quot_nxt = '0;
        res_rem_nxt  = '0;
        res_dz_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q     <= '0;
      prem_q     <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      res_dz_q   <= 1'b0;
    end else begin
      quot_q     <= quot_nxt;
      prem_q     <= prem_nxt;
      dvs_q      <= dvs_nxt;
      cnt_q      <= cnt_nxt;
      res_quot_q <= res_quot_nxt;
      res_rem_q  <= res_rem_nxt;
      res_dz_q   <= res_dz_nxt;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_quot  = res_quot_q;
  assign bus.out_rem   = res_rem_q;
  assign bus.out_dz    = res_dz_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_p_div.sv
// Directed bench for p_div: timing, boundary results, back-to-back requests,
// mid-calculation reset and a multiply/divide round trip.
module tb_p_div;
  localparam int RT_ITERS = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p_div_if bus ();
  p_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [144:0] exp_q[$];   // {dz, quot, rem}

  initial begin
    #10_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [144:0] model(input logic [95:0] dvd, input logic [47:0] dvs);
    logic [95:0] q;
    logic [95:0] r;
    if (dvs == '0) return {1'b1, {96{1'b1}}, dvd[47:0]};
    q = dvd / {48'd0, dvs};
    r = dvd % {48'd0, dvs};
    return {1'b0, q, r[47:0]};
  endfunction

  function automatic logic [95:0] dvd_of(input int k);
    return {32'(k * 3 + 1), 32'hdead_beef ^ 32'(k), 32'(k * 7919)};
  endfunction

  function automatic logic [47:0] dvs_of(input int k);
    return {16'(k + 1), 32'h9e37_79b9 ^ 32'(k * 31)};
  endfunction

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic drive_req(input logic [95:0] dvd, input logic [47:0] dvs, input logic [144:0] exp);
    bus.in_valid    = 1'b1;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_dividend = ~dvd;
    bus.in_divisor  = ~dvs;
    check("busy_after_accept", 96'(bus.busy), 96'd1);
  endtask

  // Entered at the first negedge after the acceptance edge (latency 1).
  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    logic quiet;
    logic [144:0] exp;
    lat = 1;
    quiet = 1'b1;
    while (!bus.out_valid && lat < 300) begin
      if (bus.out_quot != '0 || bus.out_rem != '0 || bus.out_dz) quiet = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_quiet"}, 96'(quiet), 96'd1);
    check({tag, "_latency"}, 96'(lat), 96'(exp_lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_quot"}, bus.out_quot, exp[143:48]);
    check({tag, "_rem"}, 96'(bus.out_rem), 96'(exp[47:0]));
    check({tag, "_dz"}, 96'(bus.out_dz), 96'(exp[144]));
    @(negedge clk);
    check({tag, "_valid_drop"}, 96'(bus.out_valid), 96'd0);
    check({tag, "_idle"}, 96'(bus.busy), 96'd0);
    check({tag, "_quot_clr"}, bus.out_quot, 96'd0);
    check({tag, "_rem_clr"}, 96'(bus.out_rem), 96'd0);
  endtask

  initial begin
    logic [46:0] a;
    logic [46:0] b;
    logic [47:0] c;
    logic [47:0] sum;
    logic [95:0] prod;
    logic [144:0] exp;
    int vcount;

    bus.in_valid    = 1'b1;
    bus.in_dividend = 96'd100;
    bus.in_divisor  = 48'd7;
    repeat (3) @(negedge clk);
    check("rst_busy", 96'(bus.busy), 96'd0);
    check("rst_valid", 96'(bus.out_valid), 96'd0);
    check("rst_quot", bus.out_quot, 96'd0);
    check("rst_rem", 96'(bus.out_rem), 96'd0);
    check("rst_dz", 96'(bus.out_dz), 96'd0);
    check("rst_state", 96'(bus.dbg_state), 96'd0);

    // First rising edge after release accepts 100/7.
    rst_n = 1'b1;
    drive_req(96'd100, 48'd7, {1'b0, 96'd14, 48'd2});
    wait_result("div_100_7", 97);

    drive_req({96{1'b1}}, 48'd1, {1'b0, {96{1'b1}}, 48'd0});
    wait_result("div_max_1", 97);

    drive_req(96'd5, 48'd9, {1'b0, 96'd0, 48'd5});
    wait_result("div_5_9", 97);

    drive_req(96'h1234_5678_9abc_def0_1357_abcd, 48'd0,
              {1'b1, {96{1'b1}}, 48'hdef0_1357_abcd});
    wait_result("div_zero", 1);

    // in_valid held high with operands changing every cycle.
    for (int k = 0; k <= 293; k++) begin
      if (k > 0) begin
        check("b2b_valid", 96'(bus.out_valid), 96'((k % 98) == 97));
        if (bus.out_valid) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          check("b2b_quot", bus.out_quot, exp[143:48]);
          check("b2b_rem", 96'(bus.out_rem), 96'(exp[47:0]));
          check("b2b_dz", 96'(bus.out_dz), 96'(exp[144]));
        end
      end
      if ((k % 98) == 0) exp_q.push_back(model(dvd_of(k), dvs_of(k)));
      bus.in_valid    = (k < 293);
      bus.in_dividend = dvd_of(k);
      bus.in_divisor  = dvs_of(k);
      @(negedge clk);
    end
    check("b2b_drained", 96'(exp_q.size()), 96'd0);
    check("b2b_idle", 96'(bus.busy), 96'd0);

    // Reset pulse after step 40 of CALC.
    drive_req({96{1'b1}}, 48'd3, model({96{1'b1}}, 48'd3));
    repeat (40) @(negedge clk);
    check("abort_in_calc", 96'(bus.dbg_state), 96'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 96'(bus.busy), 96'd0);
    check("abort_valid", 96'(bus.out_valid), 96'd0);
    check("abort_quot", bus.out_quot, 96'd0);
    check("abort_rem", 96'(bus.out_rem), 96'd0);
    check("abort_dz", 96'(bus.out_dz), 96'd0);
    check("abort_state", 96'(bus.dbg_state), 96'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) vcount++;
    end
    check("abort_no_result", 96'(vcount), 96'd0);
    drive_req(96'd12, 48'd4, {1'b0, 96'd3, 48'd0});
    wait_result("after_abort", 97);

    // Product of (a+b)*c divided back by c.
    for (int i = 0; i < RT_ITERS; i++) begin
      a = 47'({$urandom, $urandom});
      b = 47'({$urandom, $urandom});
      c = 48'({$urandom, $urandom});
      if (c == '0) c = 48'd1;
      sum  = {1'b0, a} + {1'b0, b};
      prod = 96'(sum) * 96'(c);
      drive_req(prod, c, {1'b0, 96'(sum), 48'd0});
      wait_result("round_trip", 97);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
